// File: rtl/dct_block_reorder.sv
// 8x8 block reorder buffer: ping-pong 64-entry banks, one filled in row-major order
// while the other is read out row-major, transposed or in JPEG zigzag order.
module dct_block_reorder #(
   parameter int W     = 15,
   parameter bit ZZ_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic [1:0]   mode,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last
);

   // state   | meaning
   // ST_IDLE | no block pending; outputs invalid
   // ST_READ | streaming the filled bank, one sample per edge, rd_cnt 0..63
   typedef enum logic {ST_IDLE, ST_READ} rd_state_t;

   localparam int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   rd_state_t    state_q, state_d;
   logic [W-1:0] bank0 [64];
   logic [W-1:0] bank1 [64];
   logic [5:0]   wr_cnt, rd_cnt, rd_addr;
   logic         wr_bank, rd_bank;
   logic [1:0]   blk_mode, rd_mode;
   logic         blk_done, rd_end;
   logic [W-1:0] rd_data;

   assign blk_done = in_valid && (wr_cnt == 6'd63);
   assign rd_end   = (state_q == ST_READ) && (rd_cnt == 6'd63);

   always_comb begin
      rd_addr = rd_cnt;
      case (rd_mode)
         2'd0:    rd_addr = rd_cnt;
         2'd2:    rd_addr = ZZ_EN ? 6'(ZZ[rd_cnt]) : {rd_cnt[2:0], rd_cnt[5:3]};
         default: rd_addr = {rd_cnt[2:0], rd_cnt[5:3]};
      endcase
   end

   assign rd_data = rd_bank ? bank1[rd_addr] : bank0[rd_addr];

   // A completing block always (re)starts readout, which gives bubble-free
   // hand-over when it lands on the rd_cnt=63 edge of the previous block.
   always_comb begin
      state_d = state_q;
      if (blk_done)
         state_d = ST_READ;
      else if (rd_end)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst && in_valid) begin
         if (wr_bank)
            bank1[wr_cnt] <= in_data;
         else
            bank0[wr_cnt] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_cnt    <= 6'd0;
         wr_bank   <= 1'b0;
         rd_cnt    <= 6'd0;
         rd_bank   <= 1'b0;
         blk_mode  <= 2'd0;
         rd_mode   <= 2'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         state_q <= state_d;
         if (in_valid) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == 6'd0)
               blk_mode <= mode;
            if (blk_done)
               wr_bank <= ~wr_bank;
         end
         out_valid <= (state_q == ST_READ);
         out_last  <= rd_end;
         if (state_q == ST_READ)
            out_data <= rd_data;
         // readout snapshots the block's mode so the next block may latch its own
         if (blk_done) begin
            rd_cnt  <= 6'd0;
            rd_bank <= wr_bank;
            rd_mode <= blk_mode;
         end else if (state_q == ST_READ) begin
            rd_cnt <= rd_cnt + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_dct_block_reorder.sv
// Scoreboard bench for dct_block_reorder: a W=15 instance for the main scenarios
// and a W=8 instance for bit-exact signed extremes with a mid-block mode flip.
module tb_dct_block_reorder;

   typedef struct {
      logic [14:0] d;
      logic        l;
      int          c;
   } exp_t;

   localparam int ZZ_TBL [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   logic        clk = 1'b0;
   logic        rst1, in_valid1, out_valid1, out_last1;
   logic [14:0] in_data1, out_data1;
   logic [1:0]  mode1;
   logic        rst2, in_valid2, out_valid2, out_last2;
   logic [7:0]  in_data2, out_data2;
   logic [1:0]  mode2;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dct_block_reorder #(.W(15), .ZZ_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_data(in_data1), .mode(mode1),
      .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1));

   dct_block_reorder #(.W(8), .ZZ_EN(1'b1)) dut_b (
      .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_data(in_data2), .mode(mode2),
      .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2));

   function automatic int map_addr(input logic [1:0] m, input int j);
      case (m)
         2'd0:    return j;
         2'd2:    return ZZ_TBL[j];
         default: return (j % 8) * 8 + j / 8;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (out_valid1) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected: out_valid=1 data=%0d at cycle %0d, nothing expected", out_data1, cyc);
         end else begin
            e = qa.pop_front();
            if (out_data1 !== e.d || out_last1 !== e.l || cyc != e.c) begin
               errors++;
               $display("FAIL a_sample: got data=%0d last=%0b cycle=%0d, want data=%0d last=%0b cycle=%0d",
                        out_data1, out_last1, cyc, e.d, e.l, e.c);
            end
         end
      end else if (out_last1 !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL a_last_idle: out_last=%0b with out_valid=0, want 0", out_last1);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (out_valid2) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected: out_valid=1 data=%0h at cycle %0d, nothing expected", out_data2, cyc);
         end else begin
            e = qb.pop_front();
            if (out_data2 !== e.d[7:0] || out_last2 !== e.l || cyc != e.c) begin
               errors++;
               $display("FAIL b_sample: got data=%0h last=%0b cycle=%0d, want data=%0h last=%0b cycle=%0d",
                        out_data2, out_last2, cyc, e.d[7:0], e.l, e.c);
            end
         end
      end else if (out_last2 !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL b_last_idle: out_last=%0b with out_valid=0, want 0", out_last2);
      end
   end

   // Drives one 64-sample block; m0 goes with sample 0, mrest with the others.
   // gap = idle cycles after each sample. Expected outputs are queued once the
   // 64th sample has been accepted, stamped with the cycle they must appear on.
   task automatic send_block(input bit sel, input int base, input bit alt,
                             input logic [1:0] m0, input logic [1:0] mrest, input int gap);
      logic [14:0] v [64];
      int   acc;
      exp_t e;
      acc = 0;
      for (int i = 0; i < 64; i++)
         v[i] = alt ? ((i % 2 == 0) ? 15'h0080 : 15'h007F) : 15'(base + i);
      for (int i = 0; i < 64; i++) begin
         if (!sel) begin
            in_valid1 = 1'b1; in_data1 = v[i]; mode1 = (i == 0) ? m0 : mrest;
         end else begin
            in_valid2 = 1'b1; in_data2 = v[i][7:0]; mode2 = (i == 0) ? m0 : mrest;
         end
         @(posedge clk); #1;
         if (i == 63) acc = cyc;
         in_valid1 = 1'b0;
         in_valid2 = 1'b0;
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      for (int j = 0; j < 64; j++) begin
         e.d = v[map_addr(m0, j)];
         e.l = (j == 63);
         e.c = acc + 1 + j;
         if (!sel) qa.push_back(e); else qb.push_back(e);
      end
   endtask

   task automatic drain(input bit sel);
      int n;
      n = 0;
      while (((!sel && qa.size() != 0) || (sel && qb.size() != 0)) && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      if ((!sel && qa.size() != 0) || (sel && qb.size() != 0)) begin
         checks++;
         errors++;
         $display("FAIL drain_%0d: %0d expected samples never appeared, want 0 left",
                  sel, sel ? qb.size() : qa.size());
      end
   endtask

   task automatic check_reset_outputs(input string name, input logic v, input logic l, input logic [14:0] d);
      checks++;
      if (v !== 1'b0 || l !== 1'b0 || d !== 15'd0) begin
         errors++;
         $display("FAIL %s: out_valid=%0b out_last=%0b out_data=%0d, want 0 0 0", name, v, l, d);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; mode1 = 2'd0;
      rst2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0; mode2 = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_a", out_valid1, out_last1, out_data1);
      check_reset_outputs("reset_b", out_valid2, out_last2, {7'd0, out_data2});
      rst1 = 1'b0;
      rst2 = 1'b0;
      @(posedge clk); #1;

      // gapless chain: transpose, zigzag, then two row-major blocks 0..127
      send_block(1'b0, 0,  1'b0, 2'd1, 2'd1, 0);
      send_block(1'b0, 0,  1'b0, 2'd2, 2'd2, 0);
      send_block(1'b0, 0,  1'b0, 2'd0, 2'd0, 0);
      send_block(1'b0, 64, 1'b0, 2'd0, 2'd0, 0);
      drain(1'b0);

      send_block(1'b0, 200, 1'b0, 2'd1, 2'd1, 1);
      send_block(1'b0, 300, 1'b0, 2'd3, 2'd0, 0);
      drain(1'b0);

      // reset while accepting sample 30; the partial block must never appear
      for (int i = 0; i < 30; i++) begin
         in_valid1 = 1'b1; in_data1 = 15'(500 + i); mode1 = 2'd1;
         @(posedge clk); #1;
      end
      rst1 = 1'b1; in_data1 = 15'd530;
      @(posedge clk); #1;
      rst1 = 1'b0; in_valid1 = 1'b0;
      check_reset_outputs("reset_mid_block", out_valid1, out_last1, out_data1);
      repeat (5) @(posedge clk); #1;
      send_block(1'b0, 100, 1'b0, 2'd0, 2'd0, 0);
      drain(1'b0);

      // W=8 extremes, mode flipped 0->2 after sample 0, then the reverse
      send_block(1'b1, 0, 1'b1, 2'd0, 2'd2, 0);
      send_block(1'b1, 0, 1'b1, 2'd2, 2'd0, 0);
      drain(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dct_block_reorder.md
DCT_BLOCK_REORDER -- requirements
Module: dct_block_reorder

Interface
REQ-001 SHALL have parameter W, default 15, sample width in bits; data is opaque and passed bit-exact.
REQ-002 SHALL have parameter ZZ_EN, default 1, which enables zigzag mode; when 0, mode 2 behaves as mode 1.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_data is accepted on this edge.
REQ-006 SHALL have port in_data  input  W  sample; each block is 64 samples in row-major order, index = row*8+col.
REQ-007 SHALL have port mode  input  2  readout order: 0 row-major, 1 transpose, 2 zigzag, 3 transpose.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid reordered sample.
REQ-009 SHALL have port out_data  output  W  reordered sample, registered.
REQ-010 SHALL have port out_last  output  1  high with the 64th sample of each output block.

Function
REQ-011 SHALL use two 64xW banks (ping-pong): write one bank while the other is read.
REQ-012 SHALL, on each edge with in_valid=1, write in_data at address wr_cnt of the write bank, then increment wr_cnt (6 bits, wraps 63->0).
REQ-013 SHALL latch mode into the block's mode register when a sample is accepted with wr_cnt=0; mode changes mid-block SHALL be ignored.
REQ-014 SHALL, on accepting the sample with wr_cnt=63, toggle the write bank and start readout of the just-filled bank with rd_cnt=0.
REQ-015 SHALL, while readout is active, read each edge at map(mode, rd_cnt), register the result to out_data with out_valid=1, and increment rd_cnt.
REQ-016 SHALL drive out_last=1 with the sample read at rd_cnt=63; readout SHALL end after that sample unless a new block completes on the same edge.
REQ-017 SHALL register block element j at edge E63+1+j, where E63 is the edge accepting the block's last sample; readout SHALL run 64 consecutive cycles regardless of in_valid.
REQ-018 SHALL use map 0: addr=j.
REQ-019 SHALL use map 1/3: addr = (j mod 8)*8 + j/8.
REQ-020 SHALL use map 2 as the JPEG zigzag order, held in a 64-entry constant table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ending 55,62,63.
REQ-021 SHALL apply no backpressure; a block takes at least 64 edges to fill, so no overflow can occur. Gapless input SHALL yield gapless output: on a block-completion edge coinciding with rd_cnt=63, the next readout SHALL begin without a bubble.
REQ-022 SHALL hold out_valid=0 and out_last=0 when no readout is active; out_data holds its last value.
REQ-023 SHALL allow write and read of different banks on the same edge; the same bank SHALL never be written and read on one edge.

Reset
REQ-024 SHALL, while rst=1 at an edge, clear wr_cnt=0, write bank=0, readout inactive, rd_cnt=0, out_valid=0, out_last=0, out_data=0.
REQ-025 SHALL give rst priority over in_valid on the same edge; reset mid-block or mid-readout SHALL discard partial and in-flight blocks.
REQ-026 SHALL NOT reset the bank memories; no stale contents SHALL ever be emitted.

Verification
REQ-027 SHALL cover: ramp 0..63, mode 1, continuous -> out 0,8,16,...,56,1,9,...,63; out_valid first at the edge after the 64th sample; out_last on 63.
REQ-028 SHALL cover: ramp 0..63, mode 2 -> out 0,1,8,16,9,2,3,10,17,24,...,62,63.
REQ-029 SHALL cover: two blocks back-to-back, mode 0, values 0..127 -> 128 contiguous valid outputs 0..127, out_last on 63 and 127.
REQ-030 SHALL cover: in_valid every other cycle, mode 1 -> readout starts 1 edge after the 64th accepted sample and emits 64 contiguous samples.
REQ-031 SHALL cover: rst at sample 30 of block 1, then a full block 100..163, mode 0 -> out_valid=0 until that block completes, then 100..163.
REQ-032 SHALL cover: W=8, samples -128/127 alternating, mode flipped 0->2 mid-block -> values bit-exact, order per the mode latched at sample 0.
